seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Downstream consumer of the two-bit counter: takes its 2-bit count as the digit-scan index and drives a 4-digit, common-anode seven-segment display.
- Holds a double-buffered 16-bit hex/BCD value; new values are committed only at frame boundaries, so no digit tears mid-scan.
- Includes a stall watchdog that blanks the display if the scan count stops advancing, so a single digit is never left lit continuously.

Parameters:
- STALL_LIMIT, 1000: consecutive cycles with an unchanged cnt_in before the display is blanked; must be ≥2.
- BLANK_LZ, 1: 1 = leading-zero blanking enabled; 0 = all four digits always shown.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cnt_in  in  2  scan index from the two-bit counter (0..3).
- load  in  1  request to write data_in/dp_in into the staging buffer.
- data_in  in  16  four nibbles; nibble d (bits 4d+3:4d) is shown on digit d.
- dp_in  in  4  decimal-point enables, bit d for digit d (1 = lit).
- ready  out  1  staging buffer empty; a load is accepted only when ready=1.
- an  out  4  anode selects, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse on each detected 3→0 wrap of cnt_in.
- stall  out  1  watchdog tripped; display blanked.

Behaviour:
- Reset (rst=0, asynchronous):
  - staging, active buffer and cnt_q all cleared to 0; pending cleared to 0.
  - Outputs: ready=1, an=4'hF, seg=7'h7F, dp=1, frame_tick=0, stall=0; stall_cnt=0.
- Load handshake:
  - Accept when load=1 and ready=1: staging <= {dp_in, data_in}, pending <= 1, so ready=0 from the next cycle.
  - load while ready=0 is ignored and has no side effects.
- Wrap detection:
  - cnt_q is cnt_in registered; wrap = (cnt_q==3 && cnt_in==0).
  - Any other discontinuity (for example 2→0 caused by a counter reset) is not a wrap.
  - On wrap: frame_tick=1 in the next cycle. If pending=1, active <= staging and pending <= 0, so ready=1 in the next cycle.
- Simultaneous events:
  - wrap with pending=0 and load in the same cycle: the load is accepted into staging and committed at the following wrap.
  - wrap with pending=1 and load in the same cycle: the commit occurs and the load is dropped, because ready was 0 in that cycle.
- Scan output, 1-cycle latency from cnt_in:
  - an <= ~(4'b1 << cnt_in).
  - seg <= hex decode of active nibble cnt_in.
  - dp <= ~active_dp[cnt_in].
- Hex decode (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (all hex).
- Leading-zero blanking (BLANK_LZ=1):
  - Digit d>0 shows seg=7'h7F when nibble d and every higher nibble are 0.
  - Digit 0 is never blanked.
  - dp is unaffected by blanking.
- Stall watchdog:
  - stall_cnt increments when cnt_in==cnt_q and clears to 0 when they differ; it saturates at STALL_LIMIT.
  - stall is registered: stall=1 once stall_cnt reaches STALL_LIMIT.
  - While stall=1: an=4'hF, seg=7'h7F, dp=1.
  - The cycle after cnt_in changes, stall=0 and normal scan output resumes.
  - Loading and committing continue while stalled.
- Reset mid-operation: pending data is lost and the display returns to blank (all outputs at reset values).

Decomposition:
- Package/header seg_pkg:
  - SEG_BLANK = 7'h7F.
  - NUM_DIGITS = 4.
  - The 16 hex segment codes.
  - Segment bit-order constants.
- One combinational sub-module, seg_hex_decode (4-bit nibble → 7-bit active-low pattern), instantiated once on the selected nibble.
- Stall counter width is $clog2(STALL_LIMIT+1).

Test Plan:
- Reset then release; cnt_in cycles 0,1,2,3 every 20 ns with no load: an=E,D,B,7; seg=40 on digit 0 and 7F on digits 1–3; dp=1.
- Reset low while scanning with pending=1: outputs immediately an=F, seg=7F, ready=1; staged data is not shown after release.
- Load data_in=16'h0125 when cnt_in=1: ready falls; display keeps its old value until cnt_in goes 3→0, then digit0=12, digit1=24, digit2=79, digit3=7F (blanked); frame_tick pulses once and ready=1. With BLANK_LZ=0, digit3=40.
- Second load while ready=0 (data_in=16'hFFFF): ignored; after the wrap the display shows 0125, not FFFF.
- Load asserted in the same cycle as a wrap with pending=1: the commit occurs and the new load is dropped. Counter jump 2→0: no frame_tick and no commit.
- Hold cnt_in=2 for STALL_LIMIT cycles (STALL_LIMIT=8): stall=1 and an=F after the 8th cycle; change cnt_in to 3 → stall=0 next cycle and an=7.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_WIDTH  = 7;

  typedef logic [3:0]           nibble_t;
  typedef logic [SEG_WIDTH-1:0] seg_t;

  // Segment bit order on the seg bus: {g,f,e,d,c,b,a}, bit 0 = segment a.
  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_bits_t;

  // All segments off (active-low).
  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low hex glyphs 0..F.
  localparam seg_t HEX_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // One displayed value: four decimal-point enables plus four nibbles.
  typedef struct packed {
    logic [NUM_DIGITS-1:0]   dp;
    logic [4*NUM_DIGITS-1:0] data;
  } disp_buf_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble to active-low seven-segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_LUT[nibble_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode scan driver with a frame-synchronous double buffer
// and a watchdog that blanks the display when the scan index stops moving.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int STALL_LIMIT = 1000,
  parameter bit BLANK_LZ    = 1'b1
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              cnt_in,
  input  logic                    load,
  input  logic [15:0]             data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    ready,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [SEG_WIDTH-1:0]    seg,
  output logic                    dp,
  output logic                    frame_tick,
  output logic                    stall
);

  localparam int                 STALL_W   = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

  logic [1:0]              cnt_q;
  disp_buf_t               staging_q, staging_d;
  disp_buf_t               active_q, active_d;
  logic                    pending_q, pending_d;
  logic [STALL_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic                    stall_q, stall_d;
  logic                    frame_tick_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  seg_t                    seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic                    wrap;
  logic                    accept;
  nibble_t                 sel_nibble;
  logic [15:0]             upper_nibbles;
  logic                    lz_blank;
  seg_t                    dec_seg;

  // Only a clean 3->0 step marks a frame boundary; other jumps are ignored.
  assign wrap   = (cnt_q == 2'd3) && (cnt_in == 2'd0);
  assign accept = load && !pending_q;
  assign ready  = !pending_q;

  // Staging/active buffer handoff: accept into staging, commit on wrap.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    staging_d = staging_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (accept) begin
      staging_d = '{dp: dp_in, data: data_in};
      pending_d = 1'b1;
    end
    if (wrap && pending_q) begin
      active_d  = staging_q;
      pending_d = 1'b0;
    end
  end

  // Watchdog: count cycles with an unchanged scan index, saturating at the limit.
  always_comb begin
    stall_cnt_d = '0;
    if (cnt_in == cnt_q) begin
      stall_cnt_d = (stall_cnt_q == STALL_MAX) ? stall_cnt_q : stall_cnt_q + 1'b1;
    end
    stall_d = (stall_cnt_d == STALL_MAX);
  end

  assign sel_nibble    = active_q.data[{cnt_in, 2'b00} +: 4];
  assign upper_nibbles = active_q.data >> {cnt_in, 2'b00};

  seg_hex_decode u_hex_decode (
    .nibble_i (sel_nibble),
    .seg_o    (dec_seg)
  );

  // Scan output: select anode, decode the digit, apply blanking and watchdog.
  always_comb begin
    lz_blank = BLANK_LZ && (cnt_in != 2'd0) && (upper_nibbles == 16'h0000);
    an_d     = ~(4'b0001 << cnt_in);
    seg_d    = lz_blank ? SEG_BLANK : dec_seg;
    dp_d     = ~active_q.dp[cnt_in];
    if (stall_d) begin
      an_d  = 4'hF;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the buffers are small registers, not RAM, so they are cleared so stale data can never show after reset.
      cnt_q        <= 2'd0;
      staging_q    <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      stall_cnt_q  <= '0;
      stall_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      an_q         <= 4'hF;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      cnt_q        <= cnt_in;
      staging_q    <= staging_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      stall_cnt_q  <= stall_cnt_d;
      stall_q      <= stall_d;
      frame_tick_q <= wrap;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;
  assign stall      = stall_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: reference model feeding a
// scoreboard queue, a table of display vectors, and hand-written corner cases.
`timescale 1ns/1ps
module tb_seg_scan_driver;

  localparam int LIM = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cnt_in = 2'd0;
  logic        load = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;

  logic        ready, frame_tick, stall, dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        ready2, frame_tick2, stall2, dp2;
  logic [3:0]  an2;
  logic [6:0]  seg2;

  always #10 clk = ~clk;

  seg_scan_driver #(.STALL_LIMIT(LIM), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .load(load), .data_in(data_in),
    .dp_in(dp_in), .ready(ready), .an(an), .seg(seg), .dp(dp),
    .frame_tick(frame_tick), .stall(stall)
  );

  seg_scan_driver #(.STALL_LIMIT(LIM), .BLANK_LZ(1'b0)) dut_nolz (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .load(load), .data_in(data_in),
    .dp_in(dp_in), .ready(ready2), .an(an2), .seg(seg2), .dp(dp2),
    .frame_tick(frame_tick2), .stall(stall2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] hex_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic [1:0]  m_cnt;
  logic        m_pending;
  logic [19:0] m_stage, m_active;
  int          m_sc;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [6:0] seg_nolz;
    logic       dp;
    logic       ready;
    logic       ft;
    logic       stall;
  } exp_t;

  exp_t sb_q[$];

  function automatic logic [6:0] model_seg(input logic [19:0] b, input int d, input bit lz);
    bit all_zero;
    if (lz && d > 0) begin
      all_zero = 1'b1;
      for (int k = d; k < 4; k++) if (b[4*k +: 4] != 4'h0) all_zero = 1'b0;
      if (all_zero) return 7'h7F;
    end
    return hex_tab[b[4*d +: 4]];
  endfunction

  task automatic model_reset();
    m_cnt = 2'd0; m_pending = 1'b0; m_stage = '0; m_active = '0; m_sc = 0;
    sb_q.delete();
  endtask

  // Drive one cycle of inputs, predict outputs, then compare after the edge.
  task automatic tick(input logic [1:0] c, input logic ld = 1'b0,
                      input logic [15:0] d = 16'h0000, input logic [3:0] p = 4'h0);
    exp_t e;
    exp_t got;
    logic wrap;
    cnt_in = c; load = ld; data_in = d; dp_in = p;
    wrap  = (m_cnt == 2'd3) && (c == 2'd0);
    m_sc  = (c == m_cnt) ? ((m_sc < LIM) ? m_sc + 1 : LIM) : 0;
    e.stall    = (m_sc >= LIM);
    e.ft       = wrap;
    e.an       = e.stall ? 4'hF : ~(4'b0001 << c);
    e.seg      = e.stall ? 7'h7F : model_seg(m_active, int'(c), 1'b1);
    e.seg_nolz = e.stall ? 7'h7F : model_seg(m_active, int'(c), 1'b0);
    e.dp       = e.stall ? 1'b1 : ~m_active[16 + int'(c)];
    if (wrap && m_pending) begin
      m_active  = m_stage;
      m_pending = 1'b0;
    end else if (ld && !m_pending) begin
      m_stage   = {p, d};
      m_pending = 1'b1;
    end
    e.ready = !m_pending;
    m_cnt   = c;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e   = sb_q.pop_front();
    got = '{an: an, seg: seg, seg_nolz: seg2, dp: dp, ready: ready, ft: frame_tick, stall: stall};
    check("scoreboard", got, e);
    check("scoreboard_nolz", {an2, dp2, ready2, frame_tick2, stall2},
          {e.an, e.dp, e.ready, e.ft, e.stall});
  endtask

  // ---------------- display vector table ----------------
  typedef struct packed {
    logic [15:0]     data;
    logic [3:0]      dpv;
    logic [3:0][6:0] segs;  // expected seg for digits 3..0
    logic [3:0]      dpo;   // expected active-low dp for digits 3..0
  } vec_t;

  vec_t       vecs [7];
  logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{16'h3210, 4'b0000, {7'h30, 7'h24, 7'h79, 7'h40}, 4'b1111};
    vecs[1] = '{16'h7654, 4'b0101, {7'h78, 7'h02, 7'h12, 7'h19}, 4'b1010};
    vecs[2] = '{16'hBA98, 4'b1000, {7'h03, 7'h08, 7'h10, 7'h00}, 4'b0111};
    vecs[3] = '{16'hFEDC, 4'b1111, {7'h0E, 7'h06, 7'h21, 7'h46}, 4'b0000};
    vecs[4] = '{16'h0000, 4'b0010, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1101};
    vecs[5] = '{16'h0500, 4'b0000, {7'h7F, 7'h12, 7'h40, 7'h40}, 4'b1111};
    vecs[6] = '{16'h0010, 4'b0000, {7'h7F, 7'h7F, 7'h79, 7'h40}, 4'b1111};

    model_reset();
    #2 rst = 1'b0;
    #20;
    check("reset_an", an, 4'hF);
    check("reset_seg", seg, 7'h7F);
    check("reset_dp", dp, 1'b1);
    check("reset_ready", ready, 1'b1);
    check("reset_frame_tick", frame_tick, 1'b0);
    check("reset_stall", stall, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Plain scan after reset: only digit 0 lit with a zero.
    for (int c = 0; c < 4; c++) begin
      tick(2'(c));
      check("idle_an", an, an_tab[c]);
      check("idle_seg", seg, (c == 0) ? 7'h40 : 7'h7F);
      check("idle_dp", dp, 1'b1);
    end

    // Table vectors: load on a wrap, commit at the next wrap, check a full frame.
    for (int i = 0; i < 7; i++) begin
      tick(2'd0, 1'b1, vecs[i].data, vecs[i].dpv);
      tick(2'd1); tick(2'd2); tick(2'd3);
      tick(2'd0); tick(2'd1); tick(2'd2); tick(2'd3);
      for (int c = 0; c < 4; c++) begin
        tick(2'(c));
        check("vec_an", an, an_tab[c]);
        check("vec_seg", seg, vecs[i].segs[c]);
        check("vec_dp", dp, vecs[i].dpo[c]);
      end
    end

    // Load 0125 on cnt=1, second load FFFF ignored, commit on wrap.
    tick(2'd0);
    tick(2'd1, 1'b1, 16'h0125, 4'h0);
    check("load_ready_low", ready, 1'b0);
    tick(2'd2, 1'b1, 16'hFFFF, 4'hF);
    check("old_display_kept", seg, 7'h7F);
    tick(2'd3);
    tick(2'd0);
    check("wrap_frame_tick", frame_tick, 1'b1);
    check("wrap_ready_high", ready, 1'b1);
    tick(2'd1);
    check("frame_tick_pulse", frame_tick, 1'b0);
    check("d1_0125", seg, 7'h24);
    tick(2'd2);
    check("d2_0125", seg, 7'h79);
    tick(2'd3);
    check("d3_0125_blank", seg, 7'h7F);
    check("d3_0125_nolz", seg2, 7'h40);
    tick(2'd0);
    check("d0_0125", seg, 7'h12);
    tick(2'd1);
    check("ffff_ignored", seg, 7'h24);
    check("ffff_ready", ready, 1'b1);

    // Wrap with pending=1 and a load in the same cycle: commit, drop the load.
    tick(2'd2); tick(2'd3); tick(2'd0);
    tick(2'd1, 1'b1, 16'h0987, 4'h0);
    tick(2'd2); tick(2'd3);
    tick(2'd0, 1'b1, 16'h5555, 4'h0);
    check("commit_drop_tick", frame_tick, 1'b1);
    check("commit_drop_ready", ready, 1'b1);
    tick(2'd1);
    check("commit_d1", seg, 7'h00);
    tick(2'd2); tick(2'd3); tick(2'd0); tick(2'd1);
    check("dropped_not_shown", seg, 7'h00);
    check("dropped_ready", ready, 1'b1);

    // Counter jump 2->0 is not a wrap.
    tick(2'd2, 1'b1, 16'h00A0, 4'h0);
    tick(2'd0);
    check("jump_no_tick", frame_tick, 1'b0);
    check("jump_pending", ready, 1'b0);
    tick(2'd1);
    check("jump_no_commit", seg, 7'h00);
    tick(2'd2); tick(2'd3); tick(2'd0);
    check("real_wrap_tick", frame_tick, 1'b1);
    tick(2'd1);
    check("real_wrap_commit", seg, 7'h08);

    // Stall watchdog: hold cnt_in=2.
    tick(2'd2);
    for (int k = 1; k < LIM; k++) tick(2'd2);
    check("stall_not_yet", stall, 1'b0);
    check("stall_not_yet_an", an, 4'hB);
    tick(2'd2);
    check("stall_set", stall, 1'b1);
    check("stall_an", an, 4'hF);
    check("stall_seg", seg, 7'h7F);
    check("stall_dp", dp, 1'b1);
    tick(2'd2, 1'b1, 16'h1111, 4'h0);
    check("stall_load_ready", ready, 1'b0);
    check("stall_held", stall, 1'b1);
    tick(2'd3);
    check("stall_clear", stall, 1'b0);
    check("stall_resume_an", an, 4'h7);

    // Asynchronous reset mid-cycle with pending data.
    #5 rst = 1'b0;
    #1;
    check("midrst_an", an, 4'hF);
    check("midrst_seg", seg, 7'h7F);
    check("midrst_dp", dp, 1'b1);
    check("midrst_ready", ready, 1'b1);
    check("midrst_stall", stall, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(2'd0);
    check("postrst_d0", seg, 7'h40);
    tick(2'd1); tick(2'd2); tick(2'd3); tick(2'd0);
    check("postrst_no_tick_commit", ready, 1'b1);
    tick(2'd1);
    check("postrst_staged_lost", seg, 7'h7F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
